// File: rtl/ps2_kbd_pkg.sv
// Shared PS/2 keyboard constants: prefix bytes, receiver error codes, parser states, default key map.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_kbd_pkg;

  // Prefix and receiver-error bytes
  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state_t;

  // Default command scan codes (all non-extended)
  localparam logic [7:0] KEY_UP        = 8'h1D;
  localparam logic [7:0] KEY_DOWN      = 8'h1B;
  localparam logic [7:0] KEY_NEXT      = 8'h1C;
  localparam logic [7:0] KEY_PREV      = 8'h23;
  localparam logic [7:0] KEY_RESET     = 8'h2D;
  localparam logic [7:0] KEY_FORMAT    = 8'h2B;
  localparam logic [7:0] KEY_ALARM_OFF = 8'h15;
  localparam logic [7:0] KEY_SET_TIME  = 8'h21;

  // Entry i occupies bits [9i+8:9i] = {ext, code}; entry 0 is the LSBs.
  localparam logic [71:0] DEFAULT_KEY_MAP = {
    1'b0, KEY_SET_TIME,
    1'b0, KEY_ALARM_OFF,
    1'b0, KEY_FORMAT,
    1'b0, KEY_RESET,
    1'b0, KEY_PREV,
    1'b0, KEY_NEXT,
    1'b0, KEY_DOWN,
    1'b0, KEY_UP
  };

endpackage

// File: rtl/ps2_prefix_parser.sv
// Strips E0/F0 prefixes from a PS/2 byte stream and flags each completed scan code.
// Latency: code_* is combinational with the rx_ready cycle carrying the final byte.
// Backpressure: none; every strobed byte is consumed in its cycle.
// Ports: clk, reset (sync, active-high); rx_ready/rx_byte input strobe;
//        code_valid/code_ext/code_brk/code_byte describe the completed code.
module ps2_prefix_parser
  import ps2_kbd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_ready,
  input  logic [7:0] rx_byte,
  output logic       code_valid,
  output logic       code_ext,
  output logic       code_brk,
  output logic [7:0] code_byte
);

  ps2_state_t state;
  logic       is_err;
  logic       is_ext;
  logic       is_brk;

  assign is_err = (rx_byte == PS2_ERR0) || (rx_byte == PS2_ERR1);
  assign is_ext = (rx_byte == PS2_EXT);
  assign is_brk = (rx_byte == PS2_BRK);

  // The completion flags are decoded from the registered state and the live
  // byte so the decoder's registered outputs land one cycle after rx_ready.
  // Prefix bytes never complete a code in any state; repeated or misplaced
  // prefixes simply hold the current state.
  assign code_valid = rx_ready && !is_err && !is_ext && !is_brk;
  assign code_ext   = (state == EXT) || (state == EXT_BRK);
  assign code_brk   = (state == BRK) || (state == EXT_BRK);
  assign code_byte  = rx_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (rx_ready) begin
      if (is_err) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (is_ext)      state <= EXT;
            else if (is_brk) state <= BRK;
          end
          EXT: begin
            if (is_brk)       state <= EXT_BRK;
            else if (!is_ext) state <= IDLE;
          end
          BRK, EXT_BRK: begin
            if (!is_ext && !is_brk) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_cmd_decoder.sv
// Maps PS/2 make/break codes onto command channels: press pulses, held levels, typematic repeat.
// Latency: outputs registered, 1 cycle after the rx_ready carrying the final byte of a code.
// Backpressure: none; the byte stream is consumed at line rate.
// Ports: clk, reset (sync, active-high); rx_ready/rx_byte from the PS/2 receiver;
//        key_map (9 bits per command, {ext, code}); cmd_pulse, cmd_held, unknown_pulse outputs.
module ps2_cmd_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int                  NUM_CMDS      = 8,
  parameter int                  REPEAT_DELAY  = 25000000,
  parameter int                  REPEAT_PERIOD = 5000000,
  parameter logic [NUM_CMDS-1:0] REPEAT_MASK   = 8'h03
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_ready,
  input  logic [7:0]            rx_byte,
  input  logic [9*NUM_CMDS-1:0] key_map,
  output logic [NUM_CMDS-1:0]   cmd_pulse,
  output logic [NUM_CMDS-1:0]   cmd_held,
  output logic                  unknown_pulse
);

  localparam int MAX_CYC = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
  localparam int IDX_W   = ($clog2(NUM_CMDS) < 1) ? 1 : $clog2(NUM_CMDS);

  logic             code_valid;
  logic             code_ext;
  logic             code_brk;
  logic [7:0]       code_byte;

  ps2_prefix_parser u_parser (
    .clk        (clk),
    .reset      (reset),
    .rx_ready   (rx_ready),
    .rx_byte    (rx_byte),
    .code_valid (code_valid),
    .code_ext   (code_ext),
    .code_brk   (code_brk),
    .code_byte  (code_byte)
  );

  // Repeat engine state: one shared counter owned by the latest repeatable press.
  logic             rep_active;
  logic [IDX_W-1:0] rep_owner;
  logic [CNT_W-1:0] rep_cnt;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;

  logic [NUM_CMDS-1:0] pulse_n;
  logic [NUM_CMDS-1:0] held_n;
  logic                unk_n;
  logic                active_n;
  logic [IDX_W-1:0]    owner_n;
  logic [CNT_W-1:0]    cnt_n;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (key_map[9*i +: 9] == {code_ext, code_byte}) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    pulse_n  = '0;
    held_n   = cmd_held;
    unk_n    = 1'b0;
    active_n = rep_active;
    owner_n  = rep_owner;
    cnt_n    = rep_cnt;

    // Free-running tick of the repeat engine; key events below may override it.
    if (rep_active) begin
      if (rep_cnt == '0) begin
        pulse_n[rep_owner] = 1'b1;
        cnt_n              = CNT_W'(REPEAT_PERIOD - 1);
      end else begin
        cnt_n = rep_cnt - CNT_W'(1);
      end
    end

    if (code_valid) begin
      if (!hit) begin
        unk_n = !code_brk;
      end else if (code_brk) begin
        held_n[hit_idx] = 1'b0;
        // A break of the owner beats a coincident expiry pulse.
        if (rep_active && (rep_owner == hit_idx)) begin
          active_n         = 1'b0;
          pulse_n[hit_idx] = 1'b0;
        end
      end else if (!cmd_held[hit_idx]) begin
        // Makes of an already-held key are keyboard typematic and are dropped
        // entirely, so they cannot steal back or restart the repeat engine.
        held_n[hit_idx]  = 1'b1;
        pulse_n[hit_idx] = 1'b1;
        if (REPEAT_MASK[hit_idx]) begin
          active_n = 1'b1;
          owner_n  = hit_idx;
          cnt_n    = CNT_W'(REPEAT_DELAY - 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_pulse     <= '0;
      cmd_held      <= '0;
      unknown_pulse <= 1'b0;
      rep_active    <= 1'b0;
      rep_owner     <= '0;
      rep_cnt       <= '0;
    end else begin
      cmd_pulse     <= pulse_n;
      cmd_held      <= held_n;
      unknown_pulse <= unk_n;
      rep_active    <= active_n;
      rep_owner     <= owner_n;
      rep_cnt       <= cnt_n;
    end
  end

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Directed bench for ps2_cmd_decoder: table of single-code vectors plus repeat/ownership/reset sequences.
// Latency: outputs checked on the falling edge after the capturing rising edge.
// Backpressure: n/a.
module tb_ps2_cmd_decoder;
  import ps2_kbd_pkg::*;

  logic        clk;
  logic        reset;
  logic        rx_ready;
  logic [7:0]  rx_byte;
  logic [71:0] key_map;
  logic [7:0]  cmd_pulse;
  logic [7:0]  cmd_held;
  logic        unknown_pulse;

  int errors = 0;
  int checks = 0;

  ps2_cmd_decoder #(
    .NUM_CMDS      (8),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (5),
    .REPEAT_MASK   (8'h03)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_ready      (rx_ready),
    .rx_byte       (rx_byte),
    .key_map       (key_map),
    .cmd_pulse     (cmd_pulse),
    .cmd_held      (cmd_held),
    .unknown_pulse (unknown_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         nb;
    logic [7:0] exp_pulse;
    logic [7:0] exp_held;
    logic       exp_unk;
  } vec_t;

  localparam int NV = 18;
  vec_t vec [NV];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // Present one byte (or idle) for one cycle; returns at the falling edge
  // after the capturing rising edge, where that byte's effect is visible.
  task automatic drive(input logic rdy, input logic [7:0] b);
    rx_ready = rdy;
    rx_byte  = b;
    @(negedge clk);
  endtask

  task automatic idle_expect(input string name, input int n, input logic [7:0] p, input logic [7:0] h);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 8'h00);
      check($sformatf("%s idle%0d pulse", name, k), cmd_pulse, p);
      check($sformatf("%s idle%0d held", name, k), cmd_held, h);
    end
  endtask

  initial begin
    logic [7:0] exp_p;
    logic [71:0] base_map;

    // Entry 7 is the extended code E0,75 for the whole run.
    base_map = DEFAULT_KEY_MAP;
    base_map[71:63] = 9'h175;
    key_map  = base_map;
    reset    = 1'b1;
    rx_ready = 1'b0;
    rx_byte  = 8'h00;

    vec[0]  = '{8'h1D, 8'h00, 8'h00, 1, 8'h01, 8'h01, 1'b0};
    vec[1]  = '{8'hF0, 8'h1D, 8'h00, 2, 8'h00, 8'h00, 1'b0};
    vec[2]  = '{8'h1C, 8'h00, 8'h00, 1, 8'h04, 8'h04, 1'b0};
    vec[3]  = '{8'hE0, 8'h75, 8'h00, 2, 8'h80, 8'h84, 1'b0};
    vec[4]  = '{8'h75, 8'h00, 8'h00, 1, 8'h00, 8'h84, 1'b1};
    vec[5]  = '{8'hE0, 8'hF0, 8'h75, 3, 8'h00, 8'h04, 1'b0};
    vec[6]  = '{8'h1C, 8'h00, 8'h00, 1, 8'h00, 8'h04, 1'b0};
    vec[7]  = '{8'hF0, 8'h1C, 8'h00, 2, 8'h00, 8'h00, 1'b0};
    vec[8]  = '{8'hE0, 8'h00, 8'h75, 3, 8'h00, 8'h00, 1'b1};
    vec[9]  = '{8'hF0, 8'h75, 8'h00, 2, 8'h00, 8'h00, 1'b0};
    vec[10] = '{8'hE0, 8'h1D, 8'h00, 2, 8'h00, 8'h00, 1'b1};
    vec[11] = '{8'h2D, 8'h00, 8'h00, 1, 8'h10, 8'h10, 1'b0};
    vec[12] = '{8'hF0, 8'hF0, 8'h2D, 3, 8'h00, 8'h00, 1'b0};
    vec[13] = '{8'hFF, 8'h00, 8'h00, 1, 8'h00, 8'h00, 1'b0};
    vec[14] = '{8'h1D, 8'h00, 8'h00, 1, 8'h01, 8'h01, 1'b0};
    vec[15] = '{8'h1D, 8'h00, 8'h00, 1, 8'h00, 8'h01, 1'b0};
    vec[16] = '{8'h1D, 8'h00, 8'h00, 1, 8'h00, 8'h01, 1'b0};
    vec[17] = '{8'hF0, 8'h1D, 8'h00, 2, 8'h00, 8'h00, 1'b0};

    repeat (3) @(negedge clk);
    check("reset pulse", cmd_pulse, 8'h00);
    check("reset held", cmd_held, 8'h00);
    check("reset unknown", {7'd0, unknown_pulse}, 8'h00);
    reset = 1'b0;

    // Single-code vectors
    for (int v = 0; v < NV; v++) begin
      for (int j = 0; j < vec[v].nb; j++)
        drive(1'b1, (j == 0) ? vec[v].b0 : (j == 1) ? vec[v].b1 : vec[v].b2);
      check($sformatf("vec%0d pulse", v), cmd_pulse, vec[v].exp_pulse);
      check($sformatf("vec%0d held", v), cmd_held, vec[v].exp_held);
      check($sformatf("vec%0d unknown", v), {7'd0, unknown_pulse}, {7'd0, vec[v].exp_unk});
      drive(1'b0, 8'h00);
      check($sformatf("vec%0d pulse clears", v), cmd_pulse, 8'h00);
      check($sformatf("vec%0d unknown clears", v), {7'd0, unknown_pulse}, 8'h00);
    end

    // Press/hold/release timing of a repeatable key released before its delay
    drive(1'b1, 8'h1D);
    check("t1 press pulse", cmd_pulse, 8'h01);
    idle_expect("t1", 10, 8'h00, 8'h01);
    drive(1'b1, PS2_BRK);
    check("t1 held after F0", cmd_held, 8'h01);
    drive(1'b1, 8'h1D);
    check("t1 held after break", cmd_held, 8'h00);
    check("t1 break pulse", cmd_pulse, 8'h00);
    idle_expect("t1 post", 8, 8'h00, 8'h00);

    // Auto-repeat of cmd 1: delay 20, period 5, break stops it
    drive(1'b1, 8'h1B);
    check("rep press", cmd_pulse, 8'h02);
    for (int k = 1; k <= 36; k++) begin
      drive(1'b0, 8'h00);
      exp_p = (k == 20 || k == 25 || k == 30 || k == 35) ? 8'h02 : 8'h00;
      check($sformatf("rep k%0d", k), cmd_pulse, exp_p);
    end
    drive(1'b1, PS2_BRK);
    check("rep k37", cmd_pulse, 8'h00);
    drive(1'b1, 8'h1B);
    check("rep k38 pulse", cmd_pulse, 8'h00);
    check("rep k38 held", cmd_held, 8'h00);
    idle_expect("rep post", 12, 8'h00, 8'h00);

    // Ownership transfer; releasing the old key leaves the new owner repeating;
    // break of the owner coinciding with expiry suppresses the pulse.
    drive(1'b1, 8'h1D);
    check("own 1D pulse", cmd_pulse, 8'h01);
    idle_expect("own pre", 5, 8'h00, 8'h01);
    drive(1'b1, 8'h1B);
    check("own 1B pulse", cmd_pulse, 8'h02);
    check("own 1B held", cmd_held, 8'h03);
    drive(1'b1, PS2_BRK);
    check("own k1", cmd_pulse, 8'h00);
    drive(1'b1, 8'h1D);
    check("own k2 held", cmd_held, 8'h02);
    for (int k = 3; k <= 24; k++) begin
      if (k == 24) drive(1'b1, PS2_BRK);
      else         drive(1'b0, 8'h00);
      check($sformatf("own k%0d", k), cmd_pulse, (k == 20) ? 8'h02 : 8'h00);
    end
    drive(1'b1, 8'h1B);
    check("own k25 break vs expiry pulse", cmd_pulse, 8'h00);
    check("own k25 held", cmd_held, 8'h00);
    idle_expect("own post", 8, 8'h00, 8'h00);

    // Expiry coinciding with presses of other commands
    drive(1'b1, 8'h1B);
    check("sim 1B pulse", cmd_pulse, 8'h02);
    idle_expect("sim pre", 19, 8'h00, 8'h02);
    drive(1'b1, 8'h1C);
    check("sim k20 pulse", cmd_pulse, 8'h06);
    check("sim k20 held", cmd_held, 8'h06);
    idle_expect("sim mid", 4, 8'h00, 8'h06);
    drive(1'b1, 8'h1D);
    check("sim k25 pulse", cmd_pulse, 8'h03);
    check("sim k25 held", cmd_held, 8'h07);
    for (int k = 26; k <= 45; k++) begin
      drive(1'b0, 8'h00);
      check($sformatf("sim k%0d", k), cmd_pulse, (k == 45) ? 8'h01 : 8'h00);
    end
    drive(1'b1, PS2_BRK); drive(1'b1, 8'h1D);
    drive(1'b1, PS2_BRK); drive(1'b1, 8'h1B);
    drive(1'b1, PS2_BRK); drive(1'b1, 8'h1C);
    check("sim cleanup held", cmd_held, 8'h00);
    idle_expect("sim post", 8, 8'h00, 8'h00);

    // Duplicate entries and a map change while held
    key_map = base_map;
    key_map[53:45] = 9'h01C;
    drive(1'b1, 8'h1C);
    check("dup pulse lowest", cmd_pulse, 8'h04);
    key_map[26:18] = 9'h044;
    idle_expect("map chg", 2, 8'h00, 8'h04);
    drive(1'b1, PS2_BRK); drive(1'b1, 8'h1C);
    check("map stale break held", cmd_held, 8'h04);
    check("map stale break unknown", {7'd0, unknown_pulse}, 8'h00);
    drive(1'b1, PS2_BRK); drive(1'b1, 8'h44);
    check("map new break held", cmd_held, 8'h00);
    key_map = base_map;
    drive(1'b0, 8'h00);

    // Reset mid-sequence discards the pending E0,F0 prefix
    drive(1'b1, 8'h1C);
    check("rst pre held", cmd_held, 8'h04);
    drive(1'b1, PS2_EXT);
    drive(1'b1, PS2_BRK);
    reset = 1'b1;
    drive(1'b0, 8'h00);
    reset = 1'b0;
    check("rst pulse", cmd_pulse, 8'h00);
    check("rst held", cmd_held, 8'h00);
    check("rst unknown", {7'd0, unknown_pulse}, 8'h00);
    drive(1'b1, 8'h1D);
    check("rst 1D pulse", cmd_pulse, 8'h01);
    check("rst 1D held", cmd_held, 8'h01);
    drive(1'b1, PS2_BRK); drive(1'b1, 8'h1D);
    check("rst final held", cmd_held, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
